axi_rd_resp_mem: RTL and testbench
==================================

Name: axi_rd_resp_mem

Overview:
- AXI3 read-channel responder backed by a word-addressed memory array.
- Serves the icache line fills (16-beat bursts) and single-beat reads issued by the IF-stage AXI read initiators (instr and pre_fetch buses).
- Used as the slave model in IF/icache benches and as a boot ROM stand-in.
- Read-only: the AW/W/B channels are not part of this block. Contents are preloaded through a backdoor port.

Parameters:
- ADDR_W, 12, word-index width; memory depth is 2^ADDR_W 32-bit words.
- BASE, 32'h1fc0_0000, physical byte address of word 0.
- LATENCY, 2, idle cycles between AR handshake and first rvalid (0 allowed).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- arid  input  4  transaction ID
- araddr  input  32  physical byte start address
- arlen  input  4  beats minus 1 (0..15)
- arsize  input  3  beat size; only 3'b010 is legal
- arburst  input  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- arlock/arcache/arprot  input  2/4/3  accepted and ignored
- arvalid  input  1  AR request valid
- arready  output  1  AR accept
- rid  output  4  echoed arid
- rdata  output  32  beat data
- rresp  output  2  00 OKAY, 10 SLVERR
- rlast  output  1  final beat of burst
- rvalid  output  1  R beat valid
- rready  input  1  R beat accept
- ld_we  input  1  backdoor preload write enable
- ld_addr  input  ADDR_W  preload word index
- ld_data  input  32  preload data

Behaviour:
- Reset values:
  - rvalid, rlast, rid, rdata and rresp are 0.
  - State is IDLE.
  - arready is 0 while rst is high.
- Memory contents are not reset.
- States:
  - IDLE: arready=1. On arvalid&&arready, latch id, start address, len, size, burst and beat_cnt=0. Go to WAIT if LATENCY>0, else to BEAT.
  - WAIT: arready=0. A down-counter loaded with LATENCY-1 decrements each cycle; at 0, go to BEAT.
  - BEAT: arready=0. The current beat is presented with rvalid=1.
    - On rvalid&&rready with beat_cnt==len: go to IDLE and drop rvalid next cycle.
    - Otherwise advance the address, beat_cnt++, and present the next beat in the following cycle with no bubble.
- Timing:
  - An AR handshake in cycle T gives first rvalid in cycle T+1+LATENCY.
  - Burst length = arlen+1 beats.
  - arready returns in the cycle after the last R handshake, so the minimum AR-to-AR spacing is len+2+LATENCY cycles.
- R output registers:
  - rdata, rresp, rlast and rid are registered and held stable while rvalid&&!rready.
  - rlast = (beat_cnt==len) && rvalid.
  - rid = latched arid for every beat.
- Address sequence, all on byte addresses with araddr[1:0] ignored (aligned down):
  - FIXED: address constant for every beat.
  - INCR: +4 per beat, 32-bit wraparound.
  - WRAP: the wrap boundary is (len+1)*4 bytes. The next address is (addr & ~(sz-1)) | ((addr+4) & (sz-1)).
- Word index = (addr-BASE)>>2. A beat is in range iff addr>=BASE and index<2^ADDR_W.
- rresp is SLVERR with rdata=0 for any of:
  - an out-of-range beat (checked per beat; a burst may go from OKAY to SLVERR mid-way);
  - every beat when arsize!=3'b010;
  - every beat when arburst==11;
  - every beat of a WRAP with len not in {1,3,7,15}.
- A SLVERR burst still delivers exactly len+1 beats with correct rlast.
- Preload:
  - ld_we writes mem[ld_addr] at the clock edge.
  - A beat registered in the same cycle as a write to its index returns the old data; the new value is visible from the next cycle.
- Reset mid-operation, from WAIT or BEAT: state goes to IDLE, and rvalid and rlast are 0 the cycle after rst is sampled. The aborted burst produces no further beats.
- arvalid asserted outside IDLE is ignored; the request is held by the initiator until arready.

Test Plan:
- Single beat: preload mem[0]=32'h3c08bfc0; AR at 0x1fc00000, len=0, INCR, id=3, LATENCY=2, rready=1 -> one beat 3 cycles after the handshake, rdata=32'h3c08bfc0, rid=3, rlast=1, rresp=00.
- 16-beat INCR fill with backpressure: mem[i]=i+100, araddr=0x1fc00040, len=15, rready toggling 1/0 -> 16 beats, data 116..131 in order, each beat held during stalls, rlast only on beat 16, arready high the cycle after.
- WRAP 4 beats: araddr=0x1fc0000c, len=3, mem[i]=i -> data 3,0,1,2, rlast on the 4th beat.
- Range/error: araddr=BASE+(2^ADDR_W-2)*4, INCR len=3 -> OKAY, OKAY, SLVERR, SLVERR with rdata 0. arsize=3'b011 len=1 -> 2 SLVERR beats.
- Reset mid-burst: assert rst during beat 5 of a 16-beat burst -> rvalid=0 next cycle, arready=1 after rst deasserts, and a new AR returns correct data.
- Back-to-back with LATENCY=0: two ARs held valid, id 1 then id 2 -> id 1's first beat the cycle after its handshake, id 2 accepted the cycle after id 1's rlast handshake, rid matching each burst.

Source files
------------

// File: rtl/axi_rd_if.sv
// AXI3 read-address and read-data channel bundle shared by the initiator and the
// memory responder; write channels are deliberately absent.
interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_rd_resp_mem.sv
// AXI3 read responder over a backdoor-preloaded word memory: one burst at a time,
// fixed start latency, FIXED/INCR/WRAP addressing and per-beat range checking.
module axi_rd_resp_mem #(
    parameter int unsigned ADDR_W  = 12,
    parameter logic [31:0] BASE    = 32'h1fc0_0000,
    parameter int unsigned LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    axi_rd_if.slave           s_axi,
    input  logic              i_ld_we,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [31:0]       i_ld_data
);
    localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_BEAT = 2'd2
    } state_t;

    logic [31:0]      r_mem [0:(1<<ADDR_W)-1];
    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_id;
    logic [31:0]      r_addr;
    logic [3:0]       r_len;
    logic [2:0]       r_size;
    logic [1:0]       r_burst;
    logic [3:0]       r_beat_cnt;
    logic [LAT_W-1:0] r_wait_cnt;
    logic             r_rvalid;
    logic             r_rlast;
    logic [3:0]       r_rid;
    logic [31:0]      r_rdata;
    logic [1:0]       r_rresp;

    logic             w_arready;
    logic             w_accept;
    logic             w_load;
    logic             w_advance;
    logic [31:0]      w_ld_addr;
    logic [3:0]       w_ld_len;
    logic             w_ld_berr;
    logic [3:0]       w_ld_id;
    logic [3:0]       w_ld_cnt;
    logic [31:0]      w_ld_off;
    logic             w_ld_ok;
    logic [31:0]      w_ld_word;
    logic             w_unused;

    // WRAP mask is (len+1)*4-1, i.e. len with two low ones appended
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        mask = {26'd0, len, 2'b11};
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~mask) | ((addr + 32'd4) & mask);
            default: next_addr = addr + 32'd4;
        endcase
    endfunction

    function automatic logic in_range(input logic [31:0] addr);
        logic [31:0] off;
        off      = addr - BASE;
        in_range = (addr >= BASE) && ((off >> (ADDR_W + 2)) == 32'd0);
    endfunction

    function automatic logic burst_err(input logic [3:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_bad;
        wrap_bad  = (burst == 2'b10) &&
                    !((len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15));
        burst_err = (size != 3'b010) || (burst == 2'b11) || wrap_bad;
    endfunction

    assign w_arready     = (r_state == ST_IDLE) && !rst;
    assign s_axi.arready = w_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rlast   = r_rlast;
    assign s_axi.rid     = r_rid;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;

    // Next-state and handshake decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_load       = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_arready && s_axi.arvalid) begin
                    w_accept = 1'b1;
                    if (LATENCY == 32'd0) begin
                        w_next_state = ST_BEAT;
                        w_load       = 1'b1;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == LAT_W'(0)) begin
                    w_next_state = ST_BEAT;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_BEAT: begin
                if (s_axi.rready) begin
                    if (r_beat_cnt == r_len) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_advance = 1'b1;
                        w_load    = 1'b1;
                    end
                end else begin
                    w_next_state = ST_BEAT;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Address and attributes of the beat about to be registered onto R
    always_comb begin
        w_ld_addr = r_addr;
        w_ld_len  = r_len;
        w_ld_berr = burst_err(r_len, r_size, r_burst);
        w_ld_id   = r_id;
        w_ld_cnt  = 4'd0;
        case (r_state)
            ST_IDLE: begin
                w_ld_addr = {s_axi.araddr[31:2], 2'b00};
                w_ld_len  = s_axi.arlen;
                w_ld_berr = burst_err(s_axi.arlen, s_axi.arsize, s_axi.arburst);
                w_ld_id   = s_axi.arid;
            end
            ST_BEAT: begin
                w_ld_addr = next_addr(r_addr, r_len, r_burst);
                w_ld_cnt  = r_beat_cnt + 4'd1;
            end
            default: begin
                w_ld_cnt = 4'd0;
            end
        endcase
    end

    assign w_ld_off  = w_ld_addr - BASE;
    assign w_ld_ok   = !w_ld_berr && in_range(w_ld_addr);
    assign w_ld_word = r_mem[w_ld_off[ADDR_W+1:2]];
    assign w_unused  = ^{s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.araddr[1:0], w_ld_off};

    // Backdoor preload; a same-edge read above still sees the old word
    always_ff @(posedge clk) begin
        if (i_ld_we) begin
            r_mem[i_ld_addr] <= i_ld_data;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Burst context and beat sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id       <= 4'd0;
            r_addr     <= 32'd0;
            r_len      <= 4'd0;
            r_size     <= 3'd0;
            r_burst    <= 2'd0;
            r_beat_cnt <= 4'd0;
            r_wait_cnt <= LAT_W'(0);
        end else if (w_accept) begin
            r_id       <= s_axi.arid;
            r_addr     <= {s_axi.araddr[31:2], 2'b00};
            r_len      <= s_axi.arlen;
            r_size     <= s_axi.arsize;
            r_burst    <= s_axi.arburst;
            r_beat_cnt <= 4'd0;
            r_wait_cnt <= LAT_W'(LATENCY - 32'd1);
        end else if (w_advance) begin
            r_addr     <= w_ld_addr;
            r_beat_cnt <= w_ld_cnt;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt - LAT_W'(1);
        end
    end

    // Registered R channel; payload only changes when a new beat is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rid    <= 4'd0;
            r_rdata  <= 32'd0;
            r_rresp  <= 2'b00;
        end else begin
            r_rvalid <= (w_next_state == ST_BEAT);
            if (w_load) begin
                r_rdata <= w_ld_ok ? w_ld_word : 32'd0;
                r_rresp <= w_ld_ok ? 2'b00 : 2'b10;
                r_rlast <= (w_ld_cnt == w_ld_len);
                r_rid   <= w_ld_id;
            end else if (w_next_state != ST_BEAT) begin
                r_rlast <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_rd_resp_mem.sv
// Bench for axi_rd_resp_mem: directed table, randomized bursts against an
// arithmetic reference model, and hand-written reset/preload/back-to-back sequences.
module tb_axi_rd_resp_mem;
    localparam int          AW   = 12;
    localparam logic [31:0] BASE = 32'h1fc0_0000;
    localparam int          LAT  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld_we = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0] ld_data = 32'd0;

    axi_rd_if a();
    axi_rd_if b();

    axi_rd_resp_mem #(.ADDR_W(AW), .BASE(BASE), .LATENCY(LAT)) dut_a (
        .clk(clk), .rst(rst), .s_axi(a),
        .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
    );
    axi_rd_resp_mem #(.ADDR_W(AW), .BASE(BASE), .LATENCY(0)) dut_b (
        .clk(clk), .rst(rst), .s_axi(b),
        .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_data(ld_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          rmode;
        int          pre;
        logic [31:0] exp_d0;
        logic [1:0]  exp_r0;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] mem_m [0:(1<<AW)-1];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: address of beat k from the burst's start, by plain arithmetic
    function automatic logic [31:0] model_addr(input vec_t v, input int k);
        logic [31:0] a0, sz, lo;
        a0 = v.addr & 32'hffff_fffc;
        sz = (32'(v.len) + 32'd1) * 32'd4;
        case (v.burst)
            2'b00:   return a0;
            2'b10: begin
                lo = a0 - (a0 % sz);
                return lo + ((a0 - lo + 32'(4 * k)) % sz);
            end
            default: return a0 + 32'(4 * k);
        endcase
    endfunction

    function automatic void model_beat(input vec_t v, input int k,
                                       output logic [31:0] d, output logic [1:0] r);
        logic [31:0] ad, idx;
        bit bad;
        ad  = model_addr(v, k);
        idx = (ad - BASE) >> 2;
        bad = (v.size != 3'b010) || (v.burst == 2'b11) ||
              (v.burst == 2'b10 && !(v.len inside {4'd1, 4'd3, 4'd7, 4'd15}));
        if (!bad && ad >= BASE && idx < 32'(1 << AW)) begin
            d = mem_m[idx];
            r = 2'b00;
        end else begin
            d = 32'd0;
            r = 2'b10;
        end
    endfunction

    task automatic preload(input int idx, input logic [31:0] d);
        @(negedge clk);
        ld_we = 1'b1; ld_addr = idx[AW-1:0]; ld_data = d;
        @(negedge clk);
        ld_we = 1'b0;
        mem_m[idx] = d;
    endtask

    task automatic run_burst(input vec_t v, input bit chk_first);
        int c, k, g, tg;
        bit rr, first;
        logic [31:0] ed;
        logic [1:0]  er;
        @(negedge clk);
        a.arid = v.id; a.araddr = v.addr; a.arlen = v.len; a.arsize = v.size;
        a.arburst = v.burst; a.arvalid = 1'b1; a.rready = 1'b0;
        g = 0;
        while (!a.arready && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("ar_accept", a.arready, 1'b1);
        if (!a.arready) begin
            a.arvalid = 1'b0;
            return;
        end
        @(negedge clk);
        c = 1;
        a.arvalid = 1'b0;
        while (!a.rvalid && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("first_beat_latency", c, LAT + 1);
        k = 0; g = 0; tg = 0; first = 1'b1;
        while (k <= int'(v.len) && g < 200) begin
            model_beat(v, k, ed, er);
            chk("rvalid", a.rvalid, 1'b1);
            chk("rdata", a.rdata, ed);
            chk("rresp", a.rresp, er);
            chk("rid", a.rid, v.id);
            chk("rlast", a.rlast, k == int'(v.len));
            chk("arready_busy", a.arready, 1'b0);
            if (chk_first && first) begin
                chk("table_first_rdata", a.rdata, v.exp_d0);
                chk("table_first_rresp", a.rresp, v.exp_r0);
            end
            first = 1'b0;
            case (v.rmode)
                0:       rr = 1'b1;
                1:       rr = (tg % 2 == 0);
                default: rr = 1'($urandom_range(0, 1));
            endcase
            tg++;
            a.rready = rr;
            @(negedge clk);
            if (rr) k++;
            g++;
        end
        chk("beat_budget", k > int'(v.len), 1'b1);
        a.rready = 1'b0;
        chk("done_rvalid", a.rvalid, 1'b0);
        chk("done_arready", a.arready, 1'b1);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int k, g, r;
        logic [31:0] ed;
        logic [1:0]  er;

        vecs[0] = '{4'd3, 32'h1fc0_0000, 4'd0,  3'b010, 2'b01, 0, 1, 32'h3c08_bfc0, 2'b00};
        vecs[1] = '{4'd7, 32'h1fc0_0040, 4'd15, 3'b010, 2'b01, 1, 2, 32'd116,       2'b00};
        vecs[2] = '{4'd2, 32'h1fc0_000c, 4'd3,  3'b010, 2'b10, 0, 3, 32'd3,         2'b00};
        vecs[3] = '{4'd4, 32'h1fc0_3ff8, 4'd3,  3'b010, 2'b01, 0, 4, 32'hcafe_0001, 2'b00};
        vecs[4] = '{4'd5, 32'h1fc0_0000, 4'd1,  3'b011, 2'b01, 0, 0, 32'd0,         2'b10};
        vecs[5] = '{4'd6, 32'h1fc0_0010, 4'd2,  3'b010, 2'b11, 1, 0, 32'd0,         2'b10};
        vecs[6] = '{4'd8, 32'h1fc0_0020, 4'd2,  3'b010, 2'b10, 0, 0, 32'd0,         2'b10};
        vecs[7] = '{4'd9, 32'h1fc0_0012, 4'd3,  3'b010, 2'b00, 2, 2, 32'd104,       2'b00};
        vecs[8] = '{4'd1, 32'h1fbf_fffc, 4'd1,  3'b010, 2'b01, 0, 0, 32'd0,         2'b10};
        vecs[9] = '{4'hf, 32'h1fc0_0078, 4'd15, 3'b010, 2'b10, 2, 2, 32'd130,       2'b00};

        a.arid = 4'd0; a.araddr = 32'd0; a.arlen = 4'd0; a.arsize = 3'b010; a.arburst = 2'b01;
        a.arlock = 2'd0; a.arcache = 4'd0; a.arprot = 3'd0; a.arvalid = 1'b0; a.rready = 1'b0;
        b.arid = 4'd0; b.araddr = 32'd0; b.arlen = 4'd0; b.arsize = 3'b010; b.arburst = 2'b01;
        b.arlock = 2'd0; b.arcache = 4'd0; b.arprot = 3'd0; b.arvalid = 1'b0; b.rready = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_arready", a.arready, 1'b0);
        chk("reset_rvalid", a.rvalid, 1'b0);
        chk("reset_rlast", a.rlast, 1'b0);
        chk("reset_rid", a.rid, 4'd0);
        chk("reset_rdata", a.rdata, 32'd0);
        chk("reset_rresp", a.rresp, 2'b00);
        chk("reset_b_rvalid", b.rvalid, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_arready", a.arready, 1'b1);

        for (int i = 0; i < (1 << AW); i++) begin
            ld_we = 1'b1; ld_addr = i[AW-1:0]; ld_data = $urandom;
            mem_m[i] = ld_data;
            @(negedge clk);
        end
        ld_we = 1'b0;

        for (int t = 0; t < 10; t++) begin
            case (vecs[t].pre)
                1: preload(0, 32'h3c08_bfc0);
                2: for (int i = 0; i < 32; i++) preload(i, 32'(i + 100));
                3: for (int i = 0; i < 4; i++) preload(i, 32'(i));
                4: begin
                    preload((1 << AW) - 2, 32'hcafe_0001);
                    preload((1 << AW) - 1, 32'hcafe_0002);
                end
                default: ;
            endcase
            run_burst(vecs[t], 1'b1);
        end

        for (int t = 0; t < 40; t++) begin
            preload($urandom_range(0, (1 << AW) - 1), $urandom);
            r = $urandom_range(0, 9);
            if (r < 7)      v.addr = BASE + $urandom_range(0, (1 << AW) * 4 - 1);
            else if (r < 9) v.addr = BASE + 32'((1 << AW) * 4) - $urandom_range(0, 64);
            else            v.addr = BASE - $urandom_range(1, 64);
            v.id    = 4'($urandom);
            v.len   = 4'($urandom);
            v.size  = ($urandom_range(0, 7) == 0) ? 3'b001 : 3'b010;
            v.burst = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            v.rmode = 2; v.pre = 0; v.exp_d0 = 32'd0; v.exp_r0 = 2'b00;
            run_burst(v, 1'b0);
        end

        // Reset during beat 5 of a 16-beat INCR burst
        for (int i = 0; i < 32; i++) preload(i, 32'(i + 100));
        v = '{4'd5, BASE + 32'h40, 4'd15, 3'b010, 2'b01, 0, 0, 32'd0, 2'b00};
        @(negedge clk);
        a.arid = v.id; a.araddr = v.addr; a.arlen = v.len; a.arsize = v.size;
        a.arburst = v.burst; a.arvalid = 1'b1; a.rready = 1'b1;
        chk("rst_seq_ar_ready", a.arready, 1'b1);
        k = 0; g = 0;
        while (g < 60) begin
            @(negedge clk);
            a.arvalid = 1'b0;
            g++;
            if (a.rvalid) begin
                if (k == 4) break;
                k++;
            end
        end
        chk("rst_seq_beat5_data", a.rdata, 32'd120);
        rst = 1'b1; a.rready = 1'b0;
        @(negedge clk);
        chk("rst_seq_rvalid", a.rvalid, 1'b0);
        chk("rst_seq_rlast", a.rlast, 1'b0);
        chk("rst_seq_arready_in_rst", a.arready, 1'b0);
        rst = 1'b0;
        a.rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_seq_no_beats", a.rvalid, 1'b0);
            chk("rst_seq_arready", a.arready, 1'b1);
        end
        a.rready = 1'b0;
        v = '{4'd9, BASE + 32'h14, 4'd2, 3'b010, 2'b01, 0, 0, 32'd105, 2'b00};
        run_burst(v, 1'b1);

        // Write to the index in the very cycle its beat is registered
        preload(8, 32'h1111_aaaa);
        @(negedge clk);
        a.arid = 4'd6; a.araddr = BASE + 32'h20; a.arlen = 4'd0; a.arsize = 3'b010;
        a.arburst = 2'b01; a.arvalid = 1'b1; a.rready = 1'b1;
        chk("wr_race_ar_ready", a.arready, 1'b1);
        @(negedge clk);
        a.arvalid = 1'b0;
        @(negedge clk);
        ld_we = 1'b1; ld_addr = 12'd8; ld_data = 32'h2222_bbbb;
        @(negedge clk);
        ld_we = 1'b0;
        mem_m[8] = 32'h2222_bbbb;
        chk("wr_race_rvalid", a.rvalid, 1'b1);
        chk("wr_race_old_data", a.rdata, 32'h1111_aaaa);
        @(negedge clk);
        a.rready = 1'b0;
        chk("wr_race_done", a.rvalid, 1'b0);
        v = '{4'd6, BASE + 32'h20, 4'd0, 3'b010, 2'b01, 0, 0, 32'h2222_bbbb, 2'b00};
        run_burst(v, 1'b1);

        // LATENCY=0 instance: two held requests back to back
        @(negedge clk);
        b.arid = 4'd1; b.araddr = BASE + 32'h40; b.arlen = 4'd1; b.arsize = 3'b010;
        b.arburst = 2'b01; b.arvalid = 1'b1; b.rready = 1'b1;
        chk("b2b_ar1_ready", b.arready, 1'b1);
        @(negedge clk);
        b.arid = 4'd2; b.araddr = BASE + 32'h80; b.arlen = 4'd0;
        chk("b2b_id1_b0_rvalid", b.rvalid, 1'b1);
        chk("b2b_id1_b0_rid", b.rid, 4'd1);
        chk("b2b_id1_b0_rdata", b.rdata, mem_m[16]);
        chk("b2b_id1_b0_rlast", b.rlast, 1'b0);
        chk("b2b_busy_arready", b.arready, 1'b0);
        @(negedge clk);
        chk("b2b_id1_b1_rid", b.rid, 4'd1);
        chk("b2b_id1_b1_rdata", b.rdata, mem_m[17]);
        chk("b2b_id1_b1_rlast", b.rlast, 1'b1);
        @(negedge clk);
        chk("b2b_ar2_ready", b.arready, 1'b1);
        chk("b2b_gap_rvalid", b.rvalid, 1'b0);
        @(negedge clk);
        b.arvalid = 1'b0;
        v = '{4'd2, BASE + 32'h80, 4'd0, 3'b010, 2'b01, 0, 0, 32'd0, 2'b00};
        model_beat(v, 0, ed, er);
        chk("b2b_id2_rvalid", b.rvalid, 1'b1);
        chk("b2b_id2_rid", b.rid, 4'd2);
        chk("b2b_id2_rdata", b.rdata, ed);
        chk("b2b_id2_rresp", b.rresp, er);
        chk("b2b_id2_rlast", b.rlast, 1'b1);
        @(negedge clk);
        b.rready = 1'b0;
        chk("b2b_end_rvalid", b.rvalid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
